// File: rtl/prio_req_encoder.sv
// Registered 8-to-3 request encoder: sticky pending register drained one binary code at a time
// through a valid/ready output slot, with fixed-priority or round-robin selection.
module prio_req_encoder #(
    parameter bit MODE_RR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_load,
    input  logic [7:0] req_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] pending,
    output logic       drop
);

    logic [7:0] pending_q, pending_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] out_code_q, out_code_d;
    logic [2:0] last_q, last_d;
    logic       drop_q, drop_d;

    logic [2:0] sel_fix;
    logic [2:0] sel_rr;
    logic [2:0] rr_idx;
    logic       rr_found;
    logic [2:0] sel;
    logic       slot_free;
    logic       take;
    logic [7:0] clear_mask;
    logic [7:0] load_mask;

    // Lowest set bit wins: scan downward so the last hit is the lowest index.
    always_comb begin
        sel_fix = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_fix = 3'(i);
            end
        end
    end

    // Scan last+1 .. last+8 with 3-bit wrap; k = 8 revisits last itself.
    always_comb begin
        sel_rr   = 3'd0;
        rr_idx   = 3'd0;
        rr_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            rr_idx = last_q + 3'(k);
            if (!rr_found && pending_q[rr_idx]) begin
                sel_rr   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel        = MODE_RR ? sel_rr : sel_fix;
        slot_free  = !out_valid_q || out_ready;
        take       = slot_free && (pending_q != 8'h00);
        clear_mask = take ? (8'h01 << sel) : 8'h00;
        load_mask  = req_load ? req_in : 8'h00;
    end

    always_comb begin
        pending_d   = (pending_q & ~clear_mask) | load_mask;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        last_d      = last_q;
        // A bit being selected this edge is not lost when re-requested.
        drop_d      = |(load_mask & pending_q & ~clear_mask);
        if (slot_free) begin
            out_valid_d = take;
            if (take) begin
                out_code_d = sel;
                last_d     = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= 8'h00;
            out_valid_q <= 1'b0;
            out_code_q  <= 3'd0;
            last_q      <= 3'd7;
            drop_q      <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign pending   = pending_q;
    assign drop      = drop_q;

endmodule

// File: doc/prio_req_encoder.md
# prio_req_encoder

Registered 8-to-3 request encoder with a valid/ready output. It is the encode-side counterpart of the team's 3-to-8 one-hot decoder. Up to eight request lines are captured into a sticky pending register. The block then emits the pending indices one at a time as 3-bit binary codes, so the downstream consumer can feed each code straight back into a 3-to-8 decoder. It sits between interrupt/request sources and any index-driven consumer.

## Interface
- MODE_RR, 0, selection policy: 0 = fixed priority (lowest index wins); 1 = round-robin (search starts one above the last emitted code, wrapping 7 -> 0)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_load  input  1  strobe; when 1, req_in is ORed into the pending register at this edge
- req_in  input  8  request vector; bit i = request for code i
- out_ready  input  1  consumer accepts out_code this cycle
- out_valid  output  1  out_code holds a valid index
- out_code  output  3  binary index of the request being presented
- pending  output  8  current pending register P; a code held in the output register is not in P
- drop  output  1  one-cycle pulse: a loaded request bit hit an already-pending bit and was merged (lost)

## Operation
- State: pending register P[7:0], output register (out_valid, out_code), round-robin pointer last[2:0], drop register.
- Output slot is free when out_valid = 0, or when out_valid = 1 and out_ready = 1 (transfer).
- When the slot is free and P != 0:
  - select index s from P;
  - at the clock edge, load out_code <= s and out_valid <= 1;
  - clear P[s];
  - set last <= s.
- When the slot is free and P = 0: out_valid <= 0; out_code and last hold.
- Fixed mode selection: s = lowest set bit of P.
- Round-robin selection: s = first set bit scanning last+1, last+2, ... modulo 8. The pointer moves in both modes but is only used when MODE_RR = 1.
- Selection uses the registered P only. req_in loaded in the same cycle is not visible to selection until the next cycle.
- Next-state P = (P & ~clear_mask) | (req_load ? req_in : 0). clear_mask is the one-hot of s when a selection happens, otherwise 0. The set term wins, so a bit can be selected and re-requested in the same cycle and it stays pending.
- drop: registered; it is 1 in cycle t+1 iff, at edge t, req_load = 1 and some bit i satisfies req_in[i] = 1, P[i] = 1 and i is not selected at edge t.
- A request for the index currently held in out_code is not a drop. It sets P[i], and that index is emitted again.
- No arithmetic beyond the 3-bit pointer increment, which wraps 7 -> 0.

## Timing
- Reset values (asynchronous, immediate on rst high): P = 8'h00, out_valid = 0, out_code = 3'd0, drop = 0, last = 3'd7. With last = 7, the first round-robin search starts at index 0.
- Latency: with the slot free, req_load at edge t sets P at edge t; out_valid/out_code become valid after edge t+1, i.e. two cycles from strobe to code.
- Throughput: one code per cycle while out_ready = 1 and P != 0.
- Backpressure: with out_valid = 1 and out_ready = 0, out_code and out_valid hold stable and P is not cleared. Loads still merge into P.
- out_valid never drops without a transfer. out_code changes only on a transfer or when loading a free slot.
- Reset mid-stream: pending and presented codes are discarded with no transfer. Requests on the cycle rst deasserts are captured normally.
- Every output is registered; there is no combinational path from inputs to outputs.

## Test plan
- Fixed-priority drain: MODE_RR = 0, req_load with req_in = 8'hA4 at cycle 0, out_ready = 1 -> out_code 2, 5, 7 valid in cycles 2, 3, 4; out_valid = 0 in cycle 5; pending = 0.
- Backpressure: same load but out_ready = 0 for cycles 2-6 -> out_code = 2 held with out_valid = 1 and pending = 8'hA0 throughout; after out_ready = 1, codes 5 and 7 follow on consecutive cycles.
- Drop and re-request: load 8'h24, hold out_ready = 0, then load 8'h20 -> drop = 1 for exactly one cycle. Then load 8'h04 while code 2 is presented -> no drop, pending = 8'h24, and code 2 is emitted twice.
- Round-robin vs fixed: load 8'hFF and accept codes 0-3, then load 8'h02 -> with MODE_RR = 1 the sequence continues 4, 5, 6, 7, 1; with MODE_RR = 0 it continues 1, 4, 5, 6, 7.
- Simultaneous select and reload: P = 8'h01, slot free, req_load with req_in = 8'h01 -> code 0 is presented, P[0] = 1 again next cycle, drop = 0.
- Reset mid-operation: assert rst while out_valid = 1 and pending = 8'hF0 -> outputs immediately 0, pending = 0, drop = 0; after release, load 8'h80 -> code 7 two cycles later.
